// File: rtl/period_meter.sv
// period_meter: measures period and high time of an asynchronous square wave in clock cycles,
// presenting each completed period through a valid/ack handshake with overrun and loss-of-signal flags.
module period_meter #(
   parameter int CNT_W   = 27,
   parameter int TIMEOUT = 100000000
) (
   input  logic             clock_50MHZ,
   input  logic             reset_n,
   input  logic             sig_in,
   input  logic             data_ack,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             data_valid,
   output logic             overrun,
   output logic             no_signal
);
   typedef enum logic {IDLE, MEASURE} state_t;
   state_t state_q, state_d;
   logic s1_q, s2_q, d_q;
   logic [CNT_W-1:0] cnt_q, cnt_d, hi_q, hi_d, per_q, per_d, high_q, high_d, cnt_inc;
   logic valid_q, valid_d, ovr_q, ovr_d, nosig_q, nosig_d;
   logic rise, fall, res;
   always_comb begin
      rise    = s2_q & ~d_q;
      fall    = ~s2_q & d_q;
      cnt_inc = cnt_q + CNT_W'(1);
      state_d = state_q;
      cnt_d   = '0;
      hi_d    = hi_q;
      nosig_d = nosig_q;
      res     = 1'b0;
      if (state_q == IDLE) begin
         if (rise) state_d = MEASURE;
      end else begin
         cnt_d = cnt_inc;
         if (fall) hi_d = cnt_inc;
         // a rise on the timeout edge still completes the period
         if (rise) begin
            res     = 1'b1;
            cnt_d   = '0;
            nosig_d = 1'b0;
         end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
            state_d = IDLE;
            nosig_d = 1'b1;
         end
      end
      per_d   = per_q;
      high_d  = high_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (res && (!valid_q || data_ack)) begin
         per_d   = cnt_inc;
         high_d  = hi_q;
         valid_d = 1'b1;
         ovr_d   = 1'b0;
      end else if (res) begin
         ovr_d = 1'b1;
      end else if (valid_q && data_ack) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end
   always_ff @(posedge clock_50MHZ or negedge reset_n) begin
      if (!reset_n) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         d_q     <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         per_q   <= '0;
         high_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         nosig_q <= 1'b1;
      end else begin
         s1_q    <= sig_in;
         s2_q    <= s1_q;
         d_q     <= s2_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         per_q   <= per_d;
         high_q  <= high_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         nosig_q <= nosig_d;
      end
   end
   assign period_out = per_q;
   assign high_out   = high_q;
   assign data_valid = valid_q;
   assign overrun    = ovr_q;
   assign no_signal  = nosig_q;
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: two DUT instances (long and short timeout) checked against a timestamp-based reference model.
module tb_period_meter;
   localparam logic [56:0] RST_V = {27'd0, 27'd0, 3'b001};
   logic clk = 1'b0;
   logic rst_n;
   logic sig [2];
   logic ack [2];
   logic [26:0] pout [2];
   logic [26:0] hout [2];
   logic dv [2];
   logic ov [2];
   logic ns [2];
   logic [56:0] act [2];
   logic [56:0] exp_v [2];
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 2; g++) begin : u
      localparam int TO = (g == 0) ? 5000 : 200;
      period_meter #(.CNT_W(27), .TIMEOUT(TO)) dut (
         .clock_50MHZ(clk), .reset_n(rst_n), .sig_in(sig[g]), .data_ack(ack[g]),
         .period_out(pout[g]), .high_out(hout[g]), .data_valid(dv[g]),
         .overrun(ov[g]), .no_signal(ns[g]));
      // reference: edges appear two samples late; lengths are differences of capture timestamps
      logic [3:0] samp;
      int tnow, last_rise, hi, period, high;
      logic armed, valid, ovr, nosig;
      logic rise, fall, res, tmo, take;
      assign rise = samp[1] & ~samp[2];
      assign fall = ~samp[1] & samp[2];
      assign res  = rise & armed;
      assign tmo  = armed & ~rise & (tnow - last_rise == TO);
      assign take = res & (~valid | ack[g]);
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            samp <= '0; tnow <= 0; last_rise <= 0; hi <= 0; period <= 0; high <= 0;
            armed <= 1'b0; valid <= 1'b0; ovr <= 1'b0; nosig <= 1'b1;
         end else begin
            samp <= {samp[2:0], sig[g]};
            tnow <= tnow + 1;
            if (rise) begin armed <= 1'b1; last_rise <= tnow; end
            if (fall && armed) hi <= tnow - last_rise;
            if (tmo) begin armed <= 1'b0; nosig <= 1'b1; end
            if (res) nosig <= 1'b0;
            if (take) begin period <= tnow - last_rise; high <= hi; valid <= 1'b1; ovr <= 1'b0; end
            else if (res) ovr <= 1'b1;
            else if (valid && ack[g]) begin valid <= 1'b0; ovr <= 1'b0; end
         end
      end
      assign exp_v[g] = {period[26:0], high[26:0], valid, ovr, nosig};
      assign act[g]   = {pout[g], hout[g], dv[g], ov[g], ns[g]};
   end
   task automatic do_reset();
      rst_n = 1'b0; sig[0] = 1'b0; sig[1] = 1'b0; ack[0] = 1'b0; ack[1] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask
   task automatic wave(input int g, input int h, input int l);
      sig[g] = 1'b1;
      repeat (h) @(negedge clk);
      sig[g] = 1'b0;
      repeat (l) @(negedge clk);
   endtask
   task automatic test_reset();
      rst_n = 1'b1; sig[0] = 1'b0; sig[1] = 1'b0; ack[0] = 1'b0; ack[1] = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (act[i] !== RST_V) begin errors++; $display("FAIL reset inst%0d got %h expected %h", i, act[i], RST_V); end
         checks++;
         if (act[i] !== exp_v[i]) begin errors++; $display("FAIL reset_model inst%0d got %h expected %h", i, act[i], exp_v[i]); end
      end
      do_reset();
   endtask
   task automatic test_no_ack();
      do_reset();
      wave(0, 500, 500);
      wave(0, 500, 500);
      checks++;
      if (act[0] !== {27'd1000, 27'd500, 3'b100}) begin errors++; $display("FAIL first_result got %h expected %h", act[0], {27'd1000, 27'd500, 3'b100}); end
      wave(0, 500, 500);
      checks++;
      if (act[0] !== {27'd1000, 27'd500, 3'b110}) begin errors++; $display("FAIL overrun got %h expected %h", act[0], {27'd1000, 27'd500, 3'b110}); end
      checks++;
      if (act[0] !== exp_v[0]) begin errors++; $display("FAIL no_ack_model got %h expected %h", act[0], exp_v[0]); end
   endtask
   task automatic test_ack_pulse();
      do_reset();
      fork
         repeat (5) wave(0, 500, 500);
         for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            checks++;
            if (act[0] !== exp_v[0]) begin errors++; $display("FAIL ack_model cyc %0d got %h expected %h", c, act[0], exp_v[0]); end
            checks++;
            if (ov[0] !== 1'b0 || (dv[0] && (pout[0] !== 27'd1000 || hout[0] !== 27'd500)))
               begin errors++; $display("FAIL ack_data cyc %0d got %h expected 1000/500 no overrun", c, act[0]); end
            ack[0] = dv[0] & ~ack[0];
         end
      join
      ack[0] = 1'b0;
   endtask
   task automatic test_duty_ack();
      do_reset();
      wave(0, 500, 500);
      wave(0, 30, 70);
      checks++;
      if (act[0] !== {27'd1000, 27'd500, 3'b100}) begin errors++; $display("FAIL duty_pending got %h expected %h", act[0], {27'd1000, 27'd500, 3'b100}); end
      sig[0] = 1'b1;
      repeat (2) @(negedge clk);
      ack[0] = 1'b1;
      @(negedge clk);
      ack[0] = 1'b0;
      checks++;
      if (act[0] !== {27'd100, 27'd30, 3'b100}) begin errors++; $display("FAIL duty_ack got %h expected %h", act[0], {27'd100, 27'd30, 3'b100}); end
      repeat (27) @(negedge clk);
      sig[0] = 1'b0;
      repeat (70) @(negedge clk);
      checks++;
      if (act[0] !== exp_v[0]) begin errors++; $display("FAIL duty_model got %h expected %h", act[0], exp_v[0]); end
   endtask
   task automatic test_timeout();
      do_reset();
      repeat (4) wave(1, 25, 25);
      repeat (152) @(negedge clk);
      checks++;
      if (ns[1] !== 1'b0) begin errors++; $display("FAIL timeout_early got %b expected 0", ns[1]); end
      @(negedge clk);
      checks++;
      if (act[1] !== {27'd50, 27'd25, 3'b111}) begin errors++; $display("FAIL timeout got %h expected %h", act[1], {27'd50, 27'd25, 3'b111}); end
      ack[1] = 1'b1;
      @(negedge clk);
      ack[1] = 1'b0;
      checks++;
      if (act[1] !== {27'd50, 27'd25, 3'b001}) begin errors++; $display("FAIL ack_clear got %h expected %h", act[1], {27'd50, 27'd25, 3'b001}); end
      wave(1, 30, 30);
      checks++;
      if (act[1] !== {27'd50, 27'd25, 3'b001}) begin errors++; $display("FAIL rearm got %h expected %h", act[1], {27'd50, 27'd25, 3'b001}); end
      wave(1, 30, 30);
      checks++;
      if (act[1] !== {27'd60, 27'd30, 3'b100}) begin errors++; $display("FAIL after_timeout got %h expected %h", act[1], {27'd60, 27'd30, 3'b100}); end
      checks++;
      if (act[1] !== exp_v[1]) begin errors++; $display("FAIL timeout_model got %h expected %h", act[1], exp_v[1]); end
   endtask
   task automatic test_boundary();
      do_reset();
      wave(1, 100, 100);
      wave(1, 100, 100);
      checks++;
      if (act[1] !== {27'd200, 27'd100, 3'b100}) begin errors++; $display("FAIL period_eq_timeout got %h expected %h", act[1], {27'd200, 27'd100, 3'b100}); end
      wave(1, 100, 100);
      checks++;
      if (act[1] !== {27'd200, 27'd100, 3'b110}) begin errors++; $display("FAIL period_eq_timeout2 got %h expected %h", act[1], {27'd200, 27'd100, 3'b110}); end
      do_reset();
      repeat (3) wave(1, 2, 2);
      repeat (2) @(negedge clk);
      checks++;
      if (act[1] !== {27'd4, 27'd2, 3'b110}) begin errors++; $display("FAIL min_wave got %h expected %h", act[1], {27'd4, 27'd2, 3'b110}); end
      checks++;
      if (act[1] !== exp_v[1]) begin errors++; $display("FAIL min_model got %h expected %h", act[1], exp_v[1]); end
   endtask
   task automatic test_reset_mid();
      do_reset();
      wave(0, 500, 500);
      wave(0, 500, 500);
      sig[0] = 1'b1;
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (act[i] !== RST_V) begin errors++; $display("FAIL mid_reset inst%0d got %h expected %h", i, act[i], RST_V); end
      end
      sig[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      wave(0, 300, 300);
      checks++;
      if (act[0] !== RST_V) begin errors++; $display("FAIL post_reset_arm got %h expected %h", act[0], RST_V); end
      wave(0, 300, 300);
      checks++;
      if (act[0] !== {27'd600, 27'd300, 3'b100}) begin errors++; $display("FAIL post_reset got %h expected %h", act[0], {27'd600, 27'd300, 3'b100}); end
   endtask
   task automatic test_random();
      int h, l;
      do_reset();
      for (int k = 0; k < 40; k++) begin
         h = $urandom_range(2, 40);
         l = (k % 8 == 7) ? 260 : $urandom_range(2, 40);
         for (int c = 0; c < h + l; c++) begin
            sig[0] = (c < h);
            sig[1] = sig[0];
            ack[0] = ($urandom_range(0, 3) == 0);
            ack[1] = ack[0];
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
               checks++;
               if (act[i] !== exp_v[i]) begin errors++; $display("FAIL random inst%0d k%0d got %h expected %h", i, k, act[i], exp_v[i]); end
            end
         end
      end
      ack[0] = 1'b0;
      ack[1] = 1'b0;
   endtask
   initial begin
      test_reset();
      test_no_ack();
      test_ack_pulse();
      test_duty_ack();
      test_timeout();
      test_boundary();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
